// File: rtl/xilly_frame_bridge_pkg.sv
// xilly_bridge_pkg: shared frame constants, frame FSM states and counter width helper
package xilly_bridge_pkg;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int FRAME_PIX_DEF = FRAME_W * FRAME_H;
  localparam int FC_W = 16;
  typedef enum logic {IDLE_CNT, EOF_PEND} frame_st_e;
  function automatic int frame_cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xilly_frame_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO; FWFT=1 shows head on dout, FWFT=0 registers dout on pop; clr flushes
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit FWFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign empty = r_cnt == '0;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign w_push = push & !full;
  assign w_pop = pop & !empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  if (FWFT) begin : g_fwft
    assign dout = r_mem[r_rp];
  end else begin : g_std
    logic [WIDTH-1:0] r_dout;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_dout <= '0;
      else if (clr) r_dout <= '0;
      else if (w_pop) r_dout <= r_mem[r_rp];
    assign dout = r_dout;
  end
endmodule

// File: rtl/xilly_frame_bridge.sv
// xilly_frame_bridge: Xillybus write/read streams <-> ready/valid pixel core, FIFO buffered, per-frame EOF
module xilly_frame_bridge
  import xilly_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PIX_W = 24,
  parameter int DEPTH = 512,
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter bit EOF_EN = 1'b1
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  input  logic              w_open,
  input  logic              w_wren,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_open,
  input  logic              r_rden,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic              r_eof,
  output logic              pix_in_valid,
  input  logic              pix_in_ready,
  output logic [PIX_W-1:0]  pix_in_bits,
  input  logic              pix_out_valid,
  output logic              pix_out_ready,
  input  logic [PIX_W-1:0]  pix_out_bits,
  output logic [FC_W-1:0]   frame_count,
  output logic              ovf_err
);
  localparam int CW = frame_cnt_w(FRAME_PIX);
  localparam logic [CW-1:0] LAST = CW'(FRAME_PIX - 1);
  logic w_chan_rst, w_in_empty, w_out_full, w_host_pop, w_r_close, w_last, w_unused_head;
  logic r_r_open_d, r_ovf;
  logic [DATA_W-1:0] w_head;
  logic [PIX_W-1:0] w_out_dout;
  frame_st_e r_state, w_state_nxt;
  logic [CW-1:0] r_pix_cnt, w_pix_nxt;
  logic [FC_W-1:0] r_frames, w_frames_nxt;
  assign w_chan_rst = !w_open & !r_open;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .FWFT(1'b1)) u_in (
    .clk(bus_clk), .rst_n(reset_n), .clr(w_chan_rst),
    .push(w_wren), .din(w_data), .pop(pix_in_ready),
    .dout(w_head), .empty(w_in_empty), .full(w_full)
  );
  sync_fifo #(.WIDTH(PIX_W), .DEPTH(DEPTH), .FWFT(1'b0)) u_out (
    .clk(bus_clk), .rst_n(reset_n), .clr(w_chan_rst),
    .push(pix_out_valid), .din(pix_out_bits), .pop(r_rden),
    .dout(w_out_dout), .empty(r_empty), .full(w_out_full)
  );
  assign pix_in_valid = !w_in_empty;
  assign pix_in_bits = w_head[PIX_W-1:0];
  assign w_unused_head = ^w_head;
  assign pix_out_ready = !w_out_full;
  assign r_data = DATA_W'(w_out_dout);
  assign w_host_pop = r_rden & !r_empty;
  assign w_r_close = r_r_open_d & !r_open;
  assign w_last = r_pix_cnt == LAST;
  assign r_eof = EOF_EN & (r_state == EOF_PEND) & r_empty;
  assign frame_count = r_frames;
  assign ovf_err = r_ovf;
  always_ff @(posedge bus_clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE_CNT;
      r_pix_cnt <= '0;
      r_frames <= '0;
      r_ovf <= 1'b0;
      r_r_open_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pix_cnt <= w_pix_nxt;
      r_frames <= w_frames_nxt;
      r_ovf <= r_ovf | (w_wren & w_full & !w_chan_rst);
      r_r_open_d <= r_open;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt = r_pix_cnt;
    w_frames_nxt = r_frames;
    if (w_chan_rst || w_r_close) begin
      w_state_nxt = IDLE_CNT;
      w_pix_nxt = '0;
    end else if (w_host_pop) begin
      w_state_nxt = w_last ? EOF_PEND : IDLE_CNT;
      w_pix_nxt = w_last ? '0 : r_pix_cnt + 1'b1;
      w_frames_nxt = r_frames + FC_W'(w_last);
    end
  end
endmodule
